// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the 2:1 mux select arbiter.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter with bounded hold time driving the select of a 2:1 mux.
// All outputs are flops so the mux select never glitches.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_sel;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last_nxt;
    logic             w_sel_nxt;
    logic             w_rel_a;
    logic             w_rel_b;

    assign w_rel_a = !req_a || done;
    assign w_rel_b = !req_b || done;

    // Next-state, hold counter and round-robin bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;

        case (r_state)
            ST_IDLE: begin
                if (req_a && req_b)
                    w_state_nxt = (r_last == SEL_A) ? ST_GRANT_B : ST_GRANT_A;
                else if (req_a)
                    w_state_nxt = ST_GRANT_A;
                else if (req_b)
                    w_state_nxt = ST_GRANT_B;
            end
            ST_GRANT_A: begin
                if (w_rel_a && req_b)
                    w_state_nxt = ST_GRANT_B;
                else if (w_rel_a)
                    w_state_nxt = ST_IDLE;
                else if (req_b && (r_cnt == CNT_MAX))
                    w_state_nxt = ST_GRANT_B;
            end
            ST_GRANT_B: begin
                if (w_rel_b && req_a)
                    w_state_nxt = ST_GRANT_A;
                else if (w_rel_b)
                    w_state_nxt = ST_IDLE;
                else if (req_a && (r_cnt == CNT_MAX))
                    w_state_nxt = ST_GRANT_A;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Entry into a grant restarts the hold window; staying saturates.
        if ((w_state_nxt == ST_GRANT_A) && (r_state != ST_GRANT_A)) begin
            w_cnt_nxt  = '0;
            w_last_nxt = SEL_A;
            w_sel_nxt  = SEL_A;
        end else if ((w_state_nxt == ST_GRANT_B) && (r_state != ST_GRANT_B)) begin
            w_cnt_nxt  = '0;
            w_last_nxt = SEL_B;
            w_sel_nxt  = SEL_B;
        end else if ((w_state_nxt != ST_IDLE) && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_B;
            r_sel   <= SEL_A;
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt_a <= (w_state_nxt == ST_GRANT_A);
            r_gnt_b <= (w_state_nxt == ST_GRANT_B);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sel   = r_sel;
    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign busy  = r_busy;

endmodule
